led_pattern_gen: RTL

Parametrised LED/PMOD pattern generator, the successor to the single-counter board bring-up top. It drives N_CH PMOD outputs from a tick-driven pattern engine with selectable modes (binary count, bouncing scan, PWM breathe), debounces both board switches into press events for mode select and pause, and drives the two board LEDs as pause indicator and heartbeat. It instantiates as the test-pattern core under the board top.

---
 rtl/led_pattern_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: tick-driven PMOD pattern engine (count/scan/breathe)
// with debounced mode/pause switches, pause LED and heartbeat LED.
// Ports: clk, rst_n (async, active low), sw1 (mode), sw2 (pause),
//   led1 (paused), led2 (heartbeat), pmod[N_CH], mode[2].
// Build option: LED_PATTERN_PWM_EN adds BREATHE mode and PWM logic.
module led_pattern_gen #(
  parameter int N_CH            = 8,
  parameter int PRESCALE_W      = 20,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int PWM_W           = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sw1,
  input  logic            sw2,
  output logic            led1,
  output logic            led2,
  output logic [N_CH-1:0] pmod,
  output logic [1:0]      mode
);

  if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || PWM_W < 1 ||
      PRESCALE_W < 1) begin : g_param_chk
    $error("led_pattern_gen: bad parameter");
  end

  typedef enum logic [1:0] {
    M_COUNT   = 2'd0,
    M_SCAN    = 2'd1,
    M_BREATHE = 2'd2
  } mode_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

  // prescaler and tick
  logic [PRESCALE_W-1:0] pre;
  logic                  tick;

  assign tick = &pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre <= '0;
    else        pre <= pre + 1'b1;
  end

  // debounce: index 0 is sw1, index 1 is sw2
  logic [1:0]     raw;
  logic [1:0]     meta;
  logic [1:0]     sync;
  logic [1:0]     deb;
  logic [1:0]     press;
  logic [DBW-1:0] cnt [2];

  assign raw = {sw2, sw1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      sync   <= '0;
      deb    <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]   <= '0;
          deb[i]   <= sync[i];
          // only the rising debounced edge is a press
          press[i] <= sync[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // mode sequencing
  mode_t mode_r;
  mode_t nxt_mode;

  always_comb begin
    nxt_mode = M_COUNT;
    unique case (1'b1)
      (mode_r == M_COUNT): nxt_mode = M_SCAN;
`ifdef LED_PATTERN_PWM_EN
      (mode_r == M_SCAN):  nxt_mode = M_BREATHE;
`endif
      default:             nxt_mode = M_COUNT;
    endcase
  end

  // pattern engine
  logic            paused;
  logic            dir;
  logic [N_CH-1:0] pat;
  logic [N_CH-1:0] up_nxt;
  logic [N_CH-1:0] dn_nxt;

  assign up_nxt = pat << 1;
  assign dn_nxt = pat >> 1;

`ifdef LED_PATTERN_PWM_EN
  localparam logic [PWM_W-1:0] D_MAX = '1;
  localparam logic [PWM_W-1:0] D_ONE = PWM_W'(1);

  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] pwm_cnt;
  logic             duty_dn;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= M_COUNT;
      paused  <= 1'b0;
      dir     <= 1'b0;
      pat     <= '0;
      led1    <= 1'b0;
      led2    <= 1'b0;
      pmod    <= '0;
      mode    <= 2'd0;
`ifdef LED_PATTERN_PWM_EN
      duty    <= '0;
      duty_dn <= 1'b0;
      pwm_cnt <= '0;
`endif
    end else begin
      // a press takes priority over a coincident tick
      if (press[0]) begin
        mode_r <= nxt_mode;
        pat    <= (nxt_mode == M_SCAN) ? ONE_HOT0 : '0;
        dir    <= 1'b0;
        paused <= 1'b0;
`ifdef LED_PATTERN_PWM_EN
        duty    <= '0;
        duty_dn <= 1'b0;
`endif
      end else if (press[1]) begin
        paused <= ~paused;
      end else if (tick && !paused) begin
        case (mode_r)
          M_COUNT: pat <= pat + 1'b1;
          M_SCAN: begin
            if (N_CH > 1) begin
              if (!dir) begin
                pat <= up_nxt;
                if (up_nxt[N_CH-1]) dir <= 1'b1;
              end else begin
                pat <= dn_nxt;
                if (dn_nxt[0]) dir <= 1'b0;
              end
            end
          end
`ifdef LED_PATTERN_PWM_EN
          M_BREATHE: begin
            if (!duty_dn) begin
              duty <= duty + 1'b1;
              if (duty == D_MAX - 1'b1) duty_dn <= 1'b1;
            end else begin
              duty <= duty - 1'b1;
              if (duty == D_ONE) duty_dn <= 1'b0;
            end
          end
`endif
          default: ;
        endcase
      end

      led1 <= paused;
      mode <= mode_r;
      if (tick) led2 <= ~led2;

`ifdef LED_PATTERN_PWM_EN
      pwm_cnt <= pwm_cnt + 1'b1;
      if (mode_r == M_BREATHE)
        pmod <= {N_CH{pwm_cnt < duty}};
      else
        pmod <= pat;
`else
      pmod <= pat;
`endif
    end
  end

endmodule
